// File: rtl/vga_mode_scheduler.sv
// Frame-aligned pattern-mode sequencer: mode, mode_chg and gray_out update on the edge that samples frame_start (1 clk).
// No backpressure: requests accumulate in a saturating signed pending counter until frame boundaries drain them.
module vga_mode_scheduler #(
    parameter int NUM_MODES   = 4,
    parameter int AUTO_FRAMES = 120,
    parameter int PEND_MAX    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              next_req,
    input  logic              prev_req,
    input  logic              gray_req,
    input  logic              auto_en,
    output logic [1:0]        mode,
    output logic              mode_chg,
    output logic              gray_out,
    output logic signed [2:0] pend
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP} state_t;

    localparam logic [1:0]        MODE_LAST = 2'(NUM_MODES - 1);
    localparam logic [7:0]        AUTO_LAST = 8'(AUTO_FRAMES - 1);
    localparam logic signed [3:0] PMAX      = 4'(PEND_MAX);
    localparam logic signed [3:0] PMIN      = -4'(PEND_MAX);

    state_t            state, state_nxt;
    logic [7:0]        auto_cnt, auto_cnt_nxt;
    logic [1:0]        mode_nxt;
    logic signed [2:0] pend_nxt;
    logic signed [3:0] acc;
    logic              pend_zero, user_step, auto_hit, step_up, step_dn, step;

    always_comb begin
        pend_zero    = (pend == 3'sd0);
        user_step    = frame_start && !pend_zero;
        auto_hit     = frame_start && pend_zero && auto_en && !next_req && !prev_req
                       && (auto_cnt == AUTO_LAST);
        step_up      = auto_hit || (user_step && !pend[2]);
        step_dn      = user_step && pend[2];
        step         = step_up || step_dn;

        // Drain one step first using the pre-cycle count, then add the new request, then clamp.
        acc = {pend[2], pend};
        if (step_up && !auto_hit) acc = acc - 4'sd1;
        if (step_dn)              acc = acc + 4'sd1;
        if (next_req && !prev_req) acc = acc + 4'sd1;
        if (prev_req && !next_req) acc = acc - 4'sd1;
        if (acc > PMAX) acc = PMAX;
        if (acc < PMIN) acc = PMIN;
        pend_nxt = acc[2:0];

        mode_nxt = mode;
        if (step_up)      mode_nxt = (mode == MODE_LAST) ? 2'd0 : mode + 2'd1;
        else if (step_dn) mode_nxt = (mode == 2'd0) ? MODE_LAST : mode - 2'd1;

        auto_cnt_nxt = auto_cnt;
        if (!auto_en || next_req || prev_req || auto_hit) auto_cnt_nxt = 8'd0;
        else if (frame_start && pend_zero)                auto_cnt_nxt = auto_cnt + 8'd1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (step)                   state_nxt = S_STEP;
                else if (pend_nxt != 3'sd0) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (step)                   state_nxt = S_STEP;
                else if (pend_nxt == 3'sd0) state_nxt = S_IDLE;
            end
            S_STEP: begin
                if (step)                   state_nxt = S_STEP;
                else if (pend_nxt != 3'sd0) state_nxt = S_WAIT;
                else                        state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            mode     <= 2'd0;
            pend     <= 3'sd0;
            auto_cnt <= 8'd0;
            gray_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            mode     <= mode_nxt;
            pend     <= pend_nxt;
            auto_cnt <= auto_cnt_nxt;
            if (frame_start) gray_out <= gray_req;
        end
    end

    assign mode_chg = (state == S_STEP);

endmodule

// File: tb/tb_vga_mode_scheduler.sv
// Directed scenarios plus randomized traffic, checked every cycle against an arithmetic model of the mode rules.
module tb_vga_mode_scheduler;

    localparam int NM = 4;
    localparam int AF = 4;
    localparam int PM = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start, next_req, prev_req, gray_req, auto_en;
    logic [1:0]        mode;
    logic              mode_chg, gray_out;
    logic signed [2:0] pend;

    int checks = 0;
    int errors = 0;
    int m_mode, m_pend, m_cnt, m_gray, m_chg;

    vga_mode_scheduler #(.NUM_MODES(NM), .AUTO_FRAMES(AF), .PEND_MAX(PM)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .next_req(next_req),
        .prev_req(prev_req), .gray_req(gray_req), .auto_en(auto_en),
        .mode(mode), .mode_chg(mode_chg), .gray_out(gray_out), .pend(pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".mode"},     int'(mode),     m_mode);
        check({tag, ".mode_chg"}, int'(mode_chg), m_chg);
        check({tag, ".gray_out"}, int'(gray_out), m_gray);
        check({tag, ".pend"},     int'(pend),     m_pend);
    endtask

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_cnt = 0; m_gray = 0; m_chg = 0;
    endtask

    // One frame boundary drains at most one pending step; auto steps only with nothing pending.
    task automatic model_step(input bit fs, input bit nx, input bit pv);
        int dir;
        bit user, auto_step;
        user      = fs && (m_pend != 0);
        auto_step = fs && (m_pend == 0) && auto_en && !nx && !pv && (m_cnt == AF - 1);
        dir       = user ? ((m_pend > 0) ? 1 : -1) : (auto_step ? 1 : 0);
        if (!auto_en || nx || pv || auto_step) m_cnt = 0;
        else if (fs && m_pend == 0)            m_cnt = m_cnt + 1;
        m_pend = m_pend - (user ? dir : 0) + int'(nx) - int'(pv);
        if (m_pend > PM)  m_pend = PM;
        if (m_pend < -PM) m_pend = -PM;
        m_mode = (m_mode + dir + NM) % NM;
        m_chg  = (dir != 0);
        if (fs) m_gray = gray_req;
    endtask

    task automatic cyc(input bit fs, input bit nx, input bit pv);
        frame_start = fs; next_req = nx; prev_req = pv;
        @(posedge clk);
        model_step(fs, nx, pv);
        #1;
        check_all("cyc");
        frame_start = 1'b0; next_req = 1'b0; prev_req = 1'b0;
    endtask

    task automatic frame();
        cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_start = 0; next_req = 0; prev_req = 0; gray_req = 0; auto_en = 0;
        model_reset();
        #3 check_all("por");
        @(negedge clk) rst = 1'b0;

        // T2: three requests, then one step per frame
        repeat (3) begin cyc(0, 1, 0); cyc(0, 0, 0); end
        check("t2.pend3", int'(pend), 3);
        for (int k = 1; k <= 3; k++) begin
            cyc(1, 0, 0);
            check("t2.mode", int'(mode), k);
            check("t2.chg", int'(mode_chg), 1);
            check("t2.pend", int'(pend), 3 - k);
            repeat (3) cyc(0, 0, 0);
        end

        // T1: reset while waiting with two steps pending
        cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 0, 0);
        check("t1.pend2", int'(pend), 2);
        do_reset();
        check("t1.mode0", int'(mode), 0);

        // T3: saturation below zero, then wrap downward
        repeat (5) cyc(0, 0, 1);
        check("t3.sat", int'(pend), -3);
        check("t3.bits", int'(pend[2:0]), 5);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0);
            check("t3.mode", int'(mode), 3 - k);
            cyc(0, 0, 0);
        end

        // T4: cancelling requests, and request coinciding with an empty frame
        cyc(0, 1, 1);
        check("t4.cancel", int'(pend), 0);
        cyc(1, 1, 0);
        check("t4.nostep", int'(mode), 1);
        check("t4.pend1", int'(pend), 1);
        cyc(0, 0, 0);
        frame();

        // T5: auto-advance every 4th frame, restarted by a user request
        auto_en = 1'b1;
        cyc(0, 0, 0);
        begin
            int m0;
            m0 = m_mode;
            repeat (8) frame();
            check("t5.auto", int'(mode), (m0 + 2) % NM);
            repeat (2) frame();
            cyc(0, 1, 0);
            frame();
            check("t5.user", int'(mode), (m0 + 3) % NM);
            repeat (3) frame();
            check("t5.hold", int'(mode), (m0 + 3) % NM);
            frame();
            check("t5.restart", int'(mode), (m0 + 4) % NM);
        end
        auto_en = 1'b0;

        // T6: grayscale follows the frame boundary
        cyc(0, 0, 0);
        gray_req = 1'b1;
        cyc(0, 0, 0);
        check("t6.hold", int'(gray_out), 0);
        cyc(1, 0, 0);
        check("t6.rise", int'(gray_out), 1);
        check("t6.nochg", int'(mode_chg), 0);
        cyc(0, 0, 0);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) auto_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) gray_req = ~gray_req;
            if ($urandom_range(0, 999) < 3) do_reset();
            else cyc($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
